// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM states, iteration count
// and the SPECIAL-class funct codes the decoder uses to raise div_valid.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_CYCLES = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider (DIV/DIVU): one quotient bit per cycle, {rem, quo} out.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips straight to DONE.
import div_iter_pkg::*;

module div_iter #(
  parameter int unsigned DATA_W = DIV_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_valid,
  input  logic                  signed_div,
  input  logic                  annul,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stall_div
);

  localparam int unsigned CW = $clog2(DATA_W);

  div_state_e        state, state_nxt;
  logic [DATA_W-1:0] rem, quo, dvs;
  logic [CW-1:0]     cnt;
  logic              sq, sr;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   rem_ext;
  logic [DATA_W+1:0] trial;
  logic              last;

  assign abs_a = (signed_div && a[DATA_W-1]) ? -a : a;
  assign abs_b = (signed_div && b[DATA_W-1]) ? -b : b;

  // The dividend sits in quo and shifts into rem one bit per step.
  assign rem_ext = {rem, quo[DATA_W-1]};
  // One extra bit beyond DATA_W+1 keeps the borrow unambiguous when rem_ext's MSB is set.
  assign trial   = {1'b0, rem_ext} - {2'b00, dvs};
  assign last    = (cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (div_valid) begin
`ifdef DIV_ZERO_FAST_EN
        state_nxt = (b == '0) ? DIV_DONE : DIV_BUSY;
`else
        state_nxt = DIV_BUSY;
`endif
      end
      DIV_BUSY: if (last) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (annul) state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || annul) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      sq  <= 1'b0;
      sr  <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: if (div_valid) begin
          dvs <= abs_b;
          sq  <= signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
          sr  <= signed_div & a[DATA_W-1];
          cnt <= '0;
          rem <= '0;
          quo <= abs_a;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            rem <= abs_a;
            quo <= '1;
          end
`endif
        end
        DIV_BUSY: begin
          rem <= trial[DATA_W+1] ? rem_ext[DATA_W-1:0] : trial[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], ~trial[DATA_W+1]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready     = (state == DIV_DONE);
    result    = '0;
    if (ready) result = {sr ? -rem : rem, sq ? -quo : quo};
    stall_div = div_valid & ~ready & ~annul;
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed table, multi-cycle corner
// sequences (annul, held div_valid) and randomized ops against a reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst, div_valid, signed_div, annul;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, stall_div;

  int errors = 0;
  int checks = 0;

  div_iter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .signed_div(signed_div),
    .annul(annul), .a(a), .b(b), .result(result), .ready(ready),
    .stall_div(stall_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural DIV/DIVU semantics, including the divide-by-zero and overflow cases.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    int sx, sy, q, r;
    if (y == 32'd0) return {x, (s && x[31]) ? 32'h1 : 32'hFFFF_FFFF};
    if (!s) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sx = x; sy = y;
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    if (y == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Starts one divide at the next edge, scrambles operands while busy, and
  // checks latency, stall behaviour and result. hold keeps div_valid high at ready.
  task automatic run_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input string nm, input bit hold);
    int  n = 0;
    bit  got = 0;
    bit  stall_bad = 0;
    @(negedge clk);
    signed_div = s; a = x; b = y; div_valid = 1'b1;
    #1 if (!stall_div) stall_bad = 1;
    while (n < 100 && !got) begin
      @(posedge clk);
      #1 a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
      @(negedge clk);
      n++;
      if (ready) got = 1;
      else if (!stall_div) stall_bad = 1;
    end
    if (!got) begin
      chk({nm, " timeout"}, 64'(n), 64'(exp_lat(y)));
      div_valid = 1'b0;
      return;
    end
    chk({nm, " latency"}, 64'(n), 64'(exp_lat(y)));
    chk({nm, " result"}, result, exp);
    if (stall_div) stall_bad = 1;
    chk({nm, " stall"}, 64'(stall_bad), 64'd0);
    if (!hold) div_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b0, 32'd7,          32'd2,          {32'h0000_0001, 32'h0000_0003}};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}};
    vecs[4] = '{1'b0, 32'h1234_5678,  32'd0,          {32'h1234_5678, 32'hFFFF_FFFF}};
    vecs[5] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          {32'hFFFF_FFF0, 32'h0000_0001}};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[7] = '{1'b0, 32'd0,          32'd5,          {32'h0000_0000, 32'h0000_0000}};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'd1,          {32'h0000_0000, 32'h8000_0000}};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0001}};

    rst = 1'b1; div_valid = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall", 64'(stall_div), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_div(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i), 0);

    // annul during the 10th BUSY cycle, then restart two cycles later
    @(negedge clk);
    signed_div = 1'b0; a = 32'd1000; b = 32'd3; div_valid = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1 chk("annul stall", 64'(stall_div), 64'd0);
    @(negedge clk);
    annul = 1'b0; div_valid = 1'b0;
    chk("annul ready", 64'(ready), 64'd0);
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "post-annul", 0);

    // div_valid held through DONE: single pulse, second op launched from IDLE
    run_div(1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, "held1", 1);
    begin
      int n = 0;
      int pulses = 0;
      int first = 0;
      signed_div = 1'b1; a = 32'hFFFF_FF9C; b = 32'd7;
      while (n < 60 && first == 0) begin
        @(posedge clk);
        if (n >= 1) begin #1 a = $urandom; b = $urandom; end
        @(negedge clk);
        n++;
        if (ready) begin pulses++; first = n; end
      end
      chk("held pulse spacing", 64'(first), 64'd34);
      chk("held2 result", result, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7));
      div_valid = 1'b0;
      @(negedge clk);
      chk("held after ready", 64'(ready), 64'd0);
    end

    for (int i = 0; i < 150; i++) begin
      logic        s;
      logic [31:0] x, y;
      s = $urandom_range(0, 1);
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = $urandom_range(1, 15);
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(s, x, y, ref_div(s, x, y), $sformatf("rnd%0d", i), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider for the execute stage, driven by the decoder's `div_valid`/`signed_div` controls for DIV/DIVU. It accepts two operands, runs one quotient bit per cycle and returns {remainder, quotient} for the HI/LO write. While the operation is in flight it asserts a stall request so the hazard unit can freeze the front of the pipeline.

## Interface
- `DATA_W`, 32, operand width; also the number of iteration cycles.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_valid`  in  1  divide requested by the instruction held in E; held high until `ready`.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with the start.
- `annul`  in  1  flush or exception; cancels any operation.
- `a`  in  DATA_W  dividend (rs).
- `b`  in  DATA_W  divisor (rt).
- `result`  out  2*DATA_W  {HI = remainder, LO = quotient}; valid only while `ready` = 1.
- `ready`  out  1  one-cycle completion pulse.
- `stall_div`  out  1  = `div_valid` & ~`ready` & ~`annul` (combinational).

## Operation
- Three states: IDLE, BUSY, DONE. Reset and `annul` force IDLE and clear the counter, `ready` and `result`.
- IDLE, `div_valid`=1, `annul`=0:
  - latch the `signed_div` mode;
  - latch |a| and |b| (absolute values in signed mode, raw values otherwise);
  - latch sign flags: sq = a[msb]^b[msb] and sr = a[msb] (both 0 when unsigned);
  - clear the partial remainder and counter; go to BUSY.
- BUSY, each cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − |b| at DATA_W+1 bits;
  - if trial is non-negative, rem = trial and the quotient LSB = 1; otherwise LSB = 0;
  - counter increments. After the DATA_W-th step, go to DONE.
- DONE:
  - `ready`=1 for exactly one cycle;
  - `result` = {sr ? −rem : rem, sq ? −quo : quo};
  - return to IDLE unconditionally.
- A start is never accepted in DONE. This prevents a still-high `div_valid` from re-launching the same instruction.
- Divide by zero follows the restoring algorithm naturally: unsigned quotient all ones, remainder = |a|, after sign fix-up.
  - DIVU: HI = a, LO = 0xFFFFFFFF.
  - DIV: HI = a; LO = 0x00000001 if a < 0, else 0xFFFFFFFF.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0. There is no trap.
- Operand changes on `a`/`b`/`signed_div` while in BUSY are ignored.

## Timing
- Start sampled at edge T; BUSY covers T+1 … T+DATA_W; `ready` is high during cycle T+DATA_W+1 (33 cycles after start for DATA_W = 32).
- `stall_div` is high from the cycle `div_valid` rises until the `ready` cycle, and low in the `ready` cycle so the pipeline advances with the result.
- `annul` in any cycle: `stall_div` goes low in the same cycle (combinational), and the block is IDLE after the next edge. A `div_valid` sampled in that same cycle is ignored.
- `rst` and `annul` together behave as `rst`.
- Back-to-back divides: the second start is sampled in the first IDLE cycle after DONE, giving minimum spacing of DATA_W+2 cycles.
- All outputs reset to 0; state resets to IDLE.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - a start with b = 0 goes from IDLE directly to DONE;
  - `ready` is high at T+1 with the divide-by-zero results above.
- Not defined: divide by zero runs the full DATA_W iterations and produces bit-identical results at T+DATA_W+1.

## Structure
- Shared defines header holds:
  - state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`;
  - `DIV_CYCLES` (= 32);
  - the funct codes used to generate `div_valid`.
- No sub-module. The single restoring-step datapath (shift, subtract, select) is inline; it is small enough that splitting it adds no clarity.

## Test plan
- DIVU 7 / 2, start at T → `ready` at T+33, `result` = {0x00000001, 0x00000003}; `stall_div` high T … T+32.
- DIV −7 (0xFFFFFFF9) / 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFD; and 7 / −2 → HI = 0x00000001, LO = 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → HI = 0, LO = 0x80000000.
- DIVU 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF, `ready` at T+33 (T+1 with `DIV_ZERO_FAST_EN`). DIV 0xFFFFFFF0 / 0 → LO = 0x00000001.
- `annul` in the 10th BUSY cycle → no `ready`, `stall_div` low immediately. A new DIVU 100 / 7 started 2 cycles later → {2, 14} after 33 cycles.
- `div_valid` held high through DONE → exactly one `ready` pulse. A second divide started in the following IDLE cycle completes 33 cycles later.
